// File: rtl/hough_vote_accum.sv
// Hough vote accumulator: counts (r, phi) votes per frame in a bin RAM, then
// streams every bin to the max-finder in phi-major order, zeroing as it goes.
//
// state    | meaning
// CLEAR    | zero every bin after reset, one address per cycle
// VOTE     | accept votes into the read-modify-write pipe
// DRAIN    | two cycles letting the last vote reach the RAM
// SCAN     | read each bin for output and zero it
// SCAN_END | final bin on the output; flag scan_done and reopen voting
module hough_vote_accum #(
  parameter int MSB_R   = 11,
  parameter int MSB_PHI = 7,
  parameter int MSB_CNT = 15,
  parameter int N_R     = 64,
  parameter int N_PHI   = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vote_valid,
  input  logic [MSB_R:0]     vote_r,
  input  logic [MSB_PHI:0]   vote_phi,
  output logic               vote_ready,
  input  logic               frame_end,
  output logic               vote_drop,
  output logic               out_valid,
  output logic [MSB_R:0]     r_int,
  output logic [MSB_PHI:0]   phi_int,
  output logic [MSB_CNT:0]   cnt_int,
  output logic               out_last,
  output logic               scan_done
);

  localparam int DEPTH = N_R * N_PHI;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [AW-1:0]    addr_t;
  typedef logic [MSB_CNT:0] cnt_t;

  localparam addr_t             LAST_ADDR = addr_t'(DEPTH - 1);
  localparam logic [MSB_R:0]    R_LAST    = (MSB_R + 1)'(N_R - 1);

  typedef enum logic [2:0] {CLEAR, VOTE, DRAIN, SCAN, SCAN_END} state_t;

  state_t           state;
  addr_t            seq_addr;
  logic [MSB_R:0]   seq_r;
  logic [MSB_PHI:0] seq_phi;
  logic             drain_cnt;

  logic  s1_valid;
  addr_t s1_addr;
  logic  s2_valid;
  addr_t s2_addr;
  cnt_t  s2_val;

  cnt_t  mem [DEPTH];
  cnt_t  rd_data;

  logic  vote_acc;
  logic  vote_in_range;
  int    vote_lin;
  addr_t vote_addr;
  cnt_t  old_cnt;
  cnt_t  inc_cnt;
  logic  ram_we;
  addr_t ram_waddr;
  cnt_t  ram_wdata;
  addr_t ram_raddr;

  // Vote decode and the increment stage; S2 holds the value written on the
  // previous edge, which the RAM read racing that write cannot see yet.
  always_comb begin
    vote_in_range = (int'(vote_r) < N_R) && (int'(vote_phi) < N_PHI);
    vote_lin      = int'(vote_phi) * N_R + int'(vote_r);
    vote_addr     = addr_t'(vote_lin);
    vote_acc      = vote_valid && vote_ready && (state == VOTE);
    old_cnt       = (s2_valid && (s2_addr == s1_addr)) ? s2_val : rd_data;
    inc_cnt       = (old_cnt == '1) ? old_cnt : old_cnt + 1'b1;
  end

  // RAM port steering: sequential zeroing in CLEAR/SCAN, vote write-back otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr;
    ram_wdata = inc_cnt;
    ram_raddr = vote_in_range ? vote_addr : '0;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = seq_addr;
        ram_wdata = '0;
      end
      SCAN: begin
        ram_we    = 1'b1;
        ram_waddr = seq_addr;
        ram_wdata = '0;
        ram_raddr = seq_addr;
      end
      default: ram_we = s1_valid;
    endcase
  end

  // Accumulator RAM, synchronous read returning the pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_data <= mem[ram_raddr];
  end

  // Read-modify-write pipe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_val   <= '0;
    end else begin
      s1_valid <= vote_acc && vote_in_range;
      s1_addr  <= vote_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_val   <= inc_cnt;
    end
  end

  // Sequencing FSM with registered handshake and scan outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      seq_addr   <= '0;
      seq_r      <= '0;
      seq_phi    <= '0;
      drain_cnt  <= 1'b0;
      vote_ready <= 1'b0;
      vote_drop  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      scan_done  <= 1'b0;
      r_int      <= '0;
      phi_int    <= '0;
    end else begin
      vote_drop <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        CLEAR: begin
          if (seq_addr == LAST_ADDR) begin
            state      <= VOTE;
            vote_ready <= 1'b1;
            seq_addr   <= '0;
          end else begin
            seq_addr <= seq_addr + 1'b1;
          end
        end
        VOTE: begin
          vote_drop <= vote_acc && !vote_in_range;
          if (frame_end) begin
            state      <= DRAIN;
            vote_ready <= 1'b0;
            drain_cnt  <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state    <= SCAN;
            seq_addr <= '0;
            seq_r    <= '0;
            seq_phi  <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        SCAN: begin
          out_valid <= 1'b1;
          r_int     <= seq_r;
          phi_int   <= seq_phi;
          out_last  <= (seq_addr == LAST_ADDR);
          seq_addr  <= seq_addr + 1'b1;
          if (seq_r == R_LAST) begin
            seq_r   <= '0;
            seq_phi <= seq_phi + 1'b1;
          end else begin
            seq_r <= seq_r + 1'b1;
          end
          if (seq_addr == LAST_ADDR) state <= SCAN_END;
        end
        SCAN_END: begin
          state      <= VOTE;
          vote_ready <= 1'b1;
          scan_done  <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign cnt_int = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_hough_vote_accum.sv
// Bench for hough_vote_accum: a default-size instance driven frame by frame
// against a bin-count model and scan scoreboard, plus a tiny narrow-count
// instance for saturation.
module tb_hough_vote_accum;

  localparam int N_R   = 64;
  localparam int N_PHI = 180;
  localparam int DEPTH = N_R * N_PHI;
  localparam int SN_R  = 4;
  localparam int SN_PHI = 3;
  localparam int SDEPTH = SN_R * SN_PHI;

  logic        clk = 1'b0;
  logic        reset;

  logic        vote_valid;
  logic [11:0] vote_r;
  logic [7:0]  vote_phi;
  logic        vote_ready;
  logic        frame_end;
  logic        vote_drop;
  logic        out_valid;
  logic [11:0] r_int;
  logic [7:0]  phi_int;
  logic [15:0] cnt_int;
  logic        out_last;
  logic        scan_done;

  logic        s_vote_valid;
  logic [11:0] s_vote_r;
  logic [7:0]  s_vote_phi;
  logic        s_vote_ready;
  logic        s_frame_end;
  logic        s_vote_drop;
  logic        s_out_valid;
  logic [11:0] s_r_int;
  logic [7:0]  s_phi_int;
  logic [3:0]  s_cnt_int;
  logic        s_out_last;
  logic        s_scan_done;

  hough_vote_accum dut (
    .clk(clk), .reset(reset),
    .vote_valid(vote_valid), .vote_r(vote_r), .vote_phi(vote_phi),
    .vote_ready(vote_ready), .frame_end(frame_end), .vote_drop(vote_drop),
    .out_valid(out_valid), .r_int(r_int), .phi_int(phi_int), .cnt_int(cnt_int),
    .out_last(out_last), .scan_done(scan_done)
  );

  hough_vote_accum #(.MSB_CNT(3), .N_R(SN_R), .N_PHI(SN_PHI)) dut_sat (
    .clk(clk), .reset(reset),
    .vote_valid(s_vote_valid), .vote_r(s_vote_r), .vote_phi(s_vote_phi),
    .vote_ready(s_vote_ready), .frame_end(s_frame_end), .vote_drop(s_vote_drop),
    .out_valid(s_out_valid), .r_int(s_r_int), .phi_int(s_phi_int), .cnt_int(s_cnt_int),
    .out_last(s_out_last), .scan_done(s_scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] r;
    logic [7:0]  phi;
    logic [15:0] cnt;
    logic        last;
  } entry_t;

  entry_t sb_q[$];
  entry_t mon_e;
  int     exp_cnt[DEPTH];
  int     total = 0;
  int     bad = 0;
  int     out_seen = 0;
  int     drop_seen = 0;

  // Scoreboard monitor: every scan entry must match the next expected bin.
  always @(negedge clk) begin
    if (vote_drop === 1'b1) drop_seen++;
    if (out_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL scan_extra: got entry r=%0d phi=%0d cnt=%0d, required no output",
                 r_int, phi_int, cnt_int);
      end else begin
        mon_e = sb_q.pop_front();
        if (r_int !== mon_e.r || phi_int !== mon_e.phi || cnt_int !== mon_e.cnt ||
            out_last !== mon_e.last) begin
          bad++;
          $display("FAIL scan_entry %0d: got r=%0d phi=%0d cnt=%0d last=%0b, required r=%0d phi=%0d cnt=%0d last=%0b",
                   out_seen, r_int, phi_int, cnt_int, out_last,
                   mon_e.r, mon_e.phi, mon_e.cnt, mon_e.last);
        end
      end
      total++;
      if (vote_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_during_scan: got vote_ready=%0b at entry %0d, required 0",
                 vote_ready, out_seen);
      end
      out_seen++;
    end
  end

  task automatic vote1(input int r, input int phi, input bit fe);
    vote_valid = 1'b1;
    vote_r     = 12'(r);
    vote_phi   = 8'(phi);
    frame_end  = fe;
    @(posedge clk); #1;
    vote_valid = 1'b0;
    frame_end  = 1'b0;
    if (r < N_R) begin
      if (phi < N_PHI) begin
        if (exp_cnt[phi * N_R + r] < 65535) exp_cnt[phi * N_R + r]++;
      end
    end
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic push_frame_expect();
    entry_t e;
    for (int p = 0; p < N_PHI; p++) begin
      for (int r = 0; r < N_R; r++) begin
        e.r    = 12'(r);
        e.phi  = 8'(p);
        e.cnt  = 16'(exp_cnt[p * N_R + r]);
        e.last = (p == N_PHI - 1) && (r == N_R - 1);
        sb_q.push_back(e);
        exp_cnt[p * N_R + r] = 0;
      end
    end
    out_seen = 0;
  endtask

  // Called one cycle after frame_end was sampled; follows the scan to scan_done.
  task automatic wait_scan(input string name);
    int n;
    int m;
    total++;
    if (vote_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_after_frame_end: got %0b, required 0", name, vote_ready);
    end
    n = 1;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL %s first_out_latency: got %0d cycles, required 4", name, n);
    end
    m = 0;
    while (scan_done !== 1'b1 && m < DEPTH + 16) begin
      @(posedge clk); #1;
      m++;
    end
    total++;
    if (m != DEPTH) begin
      bad++;
      $display("FAIL %s scan_done_timing: got %0d cycles after first entry, required %0d",
               name, m, DEPTH);
    end
    total++;
    if (vote_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_at_scan_done: got %0b, required 1", name, vote_ready);
    end
    total++;
    if (out_seen != DEPTH) begin
      bad++;
      $display("FAIL %s entry_count: got %0d, required %0d", name, out_seen, DEPTH);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s entries_missing: got %0d left, required 0", name, sb_q.size());
    end
    @(posedge clk); #1;
    total++;
    if (scan_done !== 1'b0) begin
      bad++;
      $display("FAIL %s scan_done_width: got %0b one cycle later, required 0", name, scan_done);
    end
  endtask

  // Releases reset and counts cycles until voting opens; stray inputs must not matter.
  task automatic run_clear(input string name);
    int n;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (vote_ready !== 1'b1 && n < DEPTH + 50) begin
      frame_end  = (n == 100);
      vote_valid = (n == 200);
      vote_r     = 12'd3;
      vote_phi   = 8'd3;
      @(posedge clk); #1;
      n++;
    end
    frame_end  = 1'b0;
    vote_valid = 1'b0;
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL %s clear_length: got %0d cycles, required %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({vote_ready, vote_drop, out_valid, out_last, scan_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, required 00000",
               {vote_ready, vote_drop, out_valid, out_last, scan_done});
    end
    total++;
    if ({r_int, phi_int, cnt_int} !== 36'd0) begin
      bad++;
      $display("FAIL reset_data: got r=%0d phi=%0d cnt=%0d, required 0 0 0",
               r_int, phi_int, cnt_int);
    end
    total++;
    if (s_vote_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_sat_ready: got %0b, required 0", s_vote_ready);
    end
    run_clear("clear_after_reset");
  endtask

  task automatic test_drop_and_empty();
    drop_seen = 0;
    vote1(64, 0, 1'b0);
    total++;
    if (vote_drop !== 1'b1) begin
      bad++;
      $display("FAIL drop_r: got vote_drop=%0b, required 1", vote_drop);
    end
    vote1(0, 180, 1'b0);
    total++;
    if (vote_drop !== 1'b1) begin
      bad++;
      $display("FAIL drop_phi: got vote_drop=%0b, required 1", vote_drop);
    end
    @(posedge clk); #1;
    total++;
    if (vote_drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got vote_drop=%0b, required 0", vote_drop);
    end
    total++;
    if (drop_seen != 2) begin
      bad++;
      $display("FAIL drop_count: got %0d pulses, required 2", drop_seen);
    end
    pulse_frame_end();
    push_frame_expect();
    wait_scan("empty_scan");
  endtask

  task automatic test_single_vote();
    vote1(5, 3, 1'b0);
    @(posedge clk); #1;
    pulse_frame_end();
    push_frame_expect();
    wait_scan("single_vote");
  endtask

  task automatic test_back_to_back();
    bit pat [10] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    vote1(1, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      vote1(pat[i] ? 11 : 10, 90, i == 9);
    end
    total++;
    if (exp_cnt[90 * N_R + 10] != 7 || exp_cnt[90 * N_R + 11] != 3) begin
      bad++;
      $display("FAIL b2b_stimulus: got model counts %0d/%0d, required 7/3",
               exp_cnt[90 * N_R + 10], exp_cnt[90 * N_R + 11]);
    end
    push_frame_expect();
    wait_scan("back_to_back");
  endtask

  task automatic test_saturate();
    int idx;
    int cyc;
    logic [3:0] want;
    total++;
    if (s_vote_ready !== 1'b1) begin
      bad++;
      $display("FAIL sat_ready: got %0b, required 1", s_vote_ready);
    end
    s_vote_valid = 1'b1;
    s_vote_r     = 12'd0;
    s_vote_phi   = 8'd0;
    repeat (20) @(posedge clk);
    #1;
    s_vote_valid = 1'b0;
    s_frame_end  = 1'b1;
    @(posedge clk); #1;
    s_frame_end  = 1'b0;
    idx = 0;
    cyc = 0;
    while (cyc < 40) begin
      if (s_out_valid === 1'b1) begin
        want = (idx == 0) ? 4'd15 : 4'd0;
        total++;
        if (s_r_int !== 12'(idx % SN_R) || s_phi_int !== 8'(idx / SN_R) ||
            s_cnt_int !== want || s_out_last !== (idx == SDEPTH - 1)) begin
          bad++;
          $display("FAIL sat_entry %0d: got r=%0d phi=%0d cnt=%0d last=%0b, required r=%0d phi=%0d cnt=%0d last=%0b",
                   idx, s_r_int, s_phi_int, s_cnt_int, s_out_last,
                   idx % SN_R, idx / SN_R, want, idx == SDEPTH - 1);
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (idx != SDEPTH) begin
      bad++;
      $display("FAIL sat_entry_count: got %0d, required %0d", idx, SDEPTH);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    vote1(7, 7, 1'b0);
    pulse_frame_end();
    push_frame_expect();
    n = 0;
    while (out_seen < 500 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (out_seen < 500) begin
      bad++;
      $display("FAIL midscan_reach: got %0d entries, required 500", out_seen);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midscan_async_drop: got out_valid=%0b, required 0", out_valid);
    end
    total++;
    if ({vote_ready, r_int, phi_int, cnt_int} !== 37'd0) begin
      bad++;
      $display("FAIL midscan_reset_values: got ready=%0b r=%0d phi=%0d cnt=%0d, required all 0",
               vote_ready, r_int, phi_int, cnt_int);
    end
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_cnt[i] = 0;
    repeat (2) @(posedge clk);
    run_clear("clear_after_midscan_reset");
    vote1(2, 2, 1'b0);
    vote1(2, 2, 1'b1);
    push_frame_expect();
    wait_scan("after_midscan_reset");
  endtask

  initial begin
    reset        = 1'b0;
    vote_valid   = 1'b0;
    vote_r       = '0;
    vote_phi     = '0;
    frame_end    = 1'b0;
    s_vote_valid = 1'b0;
    s_vote_r     = '0;
    s_vote_phi   = '0;
    s_frame_end  = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_cnt[i] = 0;
    test_reset();
    test_drop_and_empty();
    test_single_vote();
    test_back_to_back();
    test_saturate();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
